// File: rtl/lcd_frame_scheduler.sv
// lcd_frame_scheduler: snapshots one 16-character screen frame and streams it to the LCD character writer, with frame-rate blinking
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   src_data           NUM_SRC packed 128-bit frames, source k at [128k+127:128k], character 0 in the MSB byte
//   src_sel            source to display; indices >= NUM_SRC show a blank frame
//   refresh_tick       one-cycle request for a frame transfer
//   blink_en           blank alternate groups of BLINK_FRAMES frames
//   char_ready         LCD driver accepts the current character
//   char_valid/data/addr  character stream towards the LCD driver (registered)
//   busy               frame transfer in progress
//   frame_done         one-cycle pulse after character 15 is accepted
module lcd_frame_scheduler #(
    parameter int         NUM_SRC      = 4,
    parameter logic [7:0] BLANK_CHAR   = 8'h20,
    parameter int         BLINK_FRAMES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_SRC*128-1:0]   src_data,
    input  logic [1:0]               src_sel,
    input  logic                     refresh_tick,
    input  logic                     blink_en,
    input  logic                     char_ready,
    output logic                     char_valid,
    output logic [7:0]               char_data,
    output logic [3:0]               char_addr,
    output logic                     busy,
    output logic                     frame_done
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
    state_t       state, state_d;
    logic [3:0]   idx, idx_d;
    logic [127:0] snap, snap_d, sel_frame;
    logic [127:0] src_frame [4];
    logic [7:0]   cnt, cnt_d;
    logic         pending, pending_d, phase, phase_d;
    logic         start, wrap, xfer, last;

    // unused source slots read as a blank frame so src_sel needs no range check
    for (genvar k = 0; k < 4; k++) begin : g_src
        if (k < NUM_SRC) begin : g_used
            assign src_frame[k] = src_data[128*k +: 128];
        end else begin : g_blank
            assign src_frame[k] = {16{BLANK_CHAR}};
        end
    end

    always_comb begin
        xfer      = state == SEND && char_ready;
        last      = xfer && idx == 4'd15;
        wrap      = state == DONE && cnt == 8'(BLINK_FRAMES - 1);
        cnt_d     = state != DONE ? cnt : wrap ? 8'd0 : cnt + 8'd1;
        phase_d   = wrap ? ~phase : phase;
        // a tick landing in DONE merges with any existing pending request
        start     = (state == IDLE && refresh_tick) || (state == DONE && (pending || refresh_tick));
        // the phase after this DONE's update decides blanking of the next frame
        sel_frame = blink_en && phase_d ? {16{BLANK_CHAR}} : src_frame[src_sel];
        snap_d    = start ? sel_frame : snap;
        idx_d     = start ? 4'd0 : xfer && !last ? idx + 4'd1 : idx;
        state_d   = start ? SEND : state == DONE ? IDLE : last ? DONE : state;
        pending_d = state == DONE ? 1'b0 : state == SEND && refresh_tick ? 1'b1 : pending;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            snap       <= '0;
            cnt        <= '0;
            pending    <= 1'b0;
            phase      <= 1'b0;
            char_valid <= 1'b0;
            char_data  <= '0;
            char_addr  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            snap       <= snap_d;
            cnt        <= cnt_d;
            pending    <= pending_d;
            phase      <= phase_d;
            char_valid <= state_d == SEND;
            // character idx sits at bit offset 8*(15-idx), i.e. {~idx,3'b0}
            char_data  <= state_d == SEND ? snap_d[{~idx_d, 3'b000} +: 8] : 8'd0;
            char_addr  <= state_d == SEND ? idx_d : 4'd0;
            busy       <= state_d != IDLE;
            frame_done <= state_d == DONE;
        end
    end
endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// tb_lcd_frame_scheduler: random stimulus against a transaction-level model of the frame scheduler
module tb_lcd_frame_scheduler;
    localparam int NS = 3;
    localparam int BF = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NS*128-1:0] src_data = '0;
    logic [1:0]      sel = 2'd0;
    logic            tick = 1'b0, blink = 1'b0, rdy = 1'b0;
    logic            char_valid, busy, frame_done;
    logic [7:0]      char_data;
    logic [3:0]      char_addr;

    int errors = 0;
    int checks = 0;

    byte unsigned src_b [4][16];
    byte unsigned fexp [16];
    int  mode = 0;
    int  pos = 0;
    int  completed = 0;
    bit  pend = 0;

    always #5 clk = ~clk;

    lcd_frame_scheduler #(.NUM_SRC(NS), .BLANK_CHAR(8'h20), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .src_data(src_data), .src_sel(sel),
        .refresh_tick(tick), .blink_en(blink), .char_ready(rdy),
        .char_valid(char_valid), .char_data(char_data), .char_addr(char_addr),
        .busy(busy), .frame_done(frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_src();
        for (int k = 0; k < NS; k++)
            for (int i = 0; i < 16; i++)
                src_data[128*k + 8*(15-i) +: 8] = src_b[k][i];
    endtask

    task automatic start_frame();
        bit blank;
        blank = int'(sel) >= NS || (blink && ((completed / BF) % 2 == 1));
        for (int i = 0; i < 16; i++) fexp[i] = blank ? 8'h20 : src_b[sel][i];
        pos  = 0;
        mode = 1;
    endtask

    // mode: 0 idle, 1 streaming character pos, 2 frame finished
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            mode = 0; pos = 0; pend = 0; completed = 0;
        end else if (mode == 0) begin
            if (tick) start_frame();
        end else if (mode == 1) begin
            if (tick) pend = 1;
            if (rdy) begin
                if (pos == 15) mode = 2;
                else pos++;
            end
        end else begin
            completed++;
            if (pend || tick) begin
                pend = 0;
                start_frame();
            end else mode = 0;
        end
        #1;
        chk("valid", char_valid, mode == 1);
        chk("busy", busy, mode != 0);
        chk("frame_done", frame_done, mode == 2);
        if (mode == 1) begin
            chk("addr", char_addr, pos);
            chk("data", char_data, fexp[pos]);
        end
    endtask

    task automatic phase(input int n, input int tick_pct, input int rdy_pct,
                         input bit blk, input int chg_pct, input int rst_pct);
        blink = blk;
        for (int c = 0; c < n; c++) begin
            tick = $urandom_range(99) < tick_pct;
            rdy  = $urandom_range(99) < rdy_pct;
            rst  = $urandom_range(999) < rst_pct;
            if ($urandom_range(99) < chg_pct) begin
                sel = 2'($urandom_range(3));
                for (int k = 0; k < NS; k++)
                    for (int i = 0; i < 16; i++) src_b[k][i] = 8'($urandom);
                drive_src();
            end
            cycle();
        end
        tick = 0; rst = 0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 16; i++) src_b[k][i] = 8'(16*k + i + 1);
        drive_src();
        cycle();
        cycle();
        chk("rst_data", char_data, 0);
        chk("rst_addr", char_addr, 0);
        rst = 0;
        sel = 2'd2;
        for (int i = 0; i < 16; i++) src_b[2][i] = 8'(8'h41 + i);
        drive_src();
        rdy = 1;
        tick = 1;
        cycle();
        tick = 0;
        for (int c = 0; c < 20; c++) cycle();
        phase(400, 5, 50, 0, 3, 0);
        phase(400, 40, 30, 0, 10, 0);
        phase(600, 30, 100, 1, 2, 0);
        phase(400, 20, 70, 1, 20, 0);
        phase(400, 15, 60, 1, 10, 15);
        sel = 2'd3;
        phase(100, 10, 90, 0, 0, 0);
        rst = 1;
        cycle();
        rst = 0;
        cycle();
        chk("end_data", char_data, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
